// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, the NOP filler word
// and the instruction buffer entry {pc, inst}.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        FLUSH      = 2'd2,
        HALT       = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

endpackage

// File: rtl/if_inst_buffer.sv
// In-order instruction buffer: synchronous FIFO of {pc, inst} entries.
// Ports: push/push_data in, pop in (head valid when !empty), flush in,
// count/full/empty out. Flush wins over push and pop in the same cycle.
module if_inst_buffer
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  ibuf_entry_t              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output ibuf_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    ibuf_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == DEPTH[AW:0]);
    assign empty = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: fetch PC, credit-limited imem requests, discard of
// stale responses after redirects, and the F2->D register for the decoder.
// Ports: clk/rst (async, active-high), imem_req_* / imem_resp_* memory side,
// redirect_valid/redirect_pc from branch resolution, stall from the hazard
// unit, f2_d_ppreg_* to decode, fetch_misaligned sticky flag.
// Build option: IF_MISALIGN_CHECK_EN halts fetch on a misaligned redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        f2_d_ppreg_is_a_inst,
    output logic [31:0] f2_d_ppreg_inst,
    output logic [31:0] f2_d_ppreg_pc,
    output logic        fetch_misaligned
);

    localparam int AW = $clog2(IBUF_DEPTH);
    localparam int CW = AW + 2;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [AW:0]   outstanding;
    logic [AW:0]   out_nxt;
    logic [AW:0]   discard;
    logic [AW:0]   disc_nxt;
    logic [AW:0]   buf_count;
    logic          buf_full;
    logic          buf_empty;
    ibuf_entry_t   buf_head;
    ibuf_entry_t   buf_in;
    logic [CW-1:0] credit;
    logic [31:0]   target_pc;
    logic          handshake;
    logic          keep_resp;
    logic          push;
    logic          pop;
    logic          misalign_hit;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // A redirect or a stall blocks the pop; redirect also empties the buffer.
    assign pop = !redirect_valid && !stall && !buf_empty;

    // Entries already buffered or in flight each hold a slot; the head
    // leaving this cycle frees one.
    assign credit = CW'(IBUF_DEPTH) + CW'(pop)
                  - CW'(buf_count) - CW'(outstanding);

    assign imem_req_valid = (state == FETCH) && (credit != '0)
                          && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign handshake      = imem_req_valid && imem_req_ready;

    assign keep_resp = imem_resp_valid && !redirect_valid
                     && (discard == '0);
    assign push      = keep_resp && (!buf_full || pop);

    assign buf_in.pc   = resp_pc;
    assign buf_in.inst = imem_resp_data;

    assign out_nxt = outstanding + {{AW{1'b0}}, handshake}
                   - {{AW{1'b0}}, imem_resp_valid};

    always_comb begin
        disc_nxt = discard;
        if (redirect_valid)
            disc_nxt = out_nxt;
        else if (imem_resp_valid && (discard != '0))
            disc_nxt = discard - 1'b1;
    end

`ifdef IF_MISALIGN_CHECK_EN
    assign misalign_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_misaligned <= 1'b0;
        else if (misalign_hit)
            fetch_misaligned <= 1'b1;
    end
`else
    assign misalign_hit     = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            RESET_WAIT: state_nxt = FETCH;
            FETCH: begin
                if (redirect_valid && (out_nxt != '0))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (disc_nxt == '0)
                    state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = state;
        endcase
        if (misalign_hit)
            state_nxt = HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= RESET_WAIT;
            fetch_pc             <= RESET_PC;
            resp_pc              <= RESET_PC;
            outstanding          <= '0;
            discard              <= '0;
            f2_d_ppreg_is_a_inst <= 1'b0;
            f2_d_ppreg_inst      <= NOP_INST;
            f2_d_ppreg_pc        <= RESET_PC;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            discard     <= disc_nxt;
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
            end else begin
                if (handshake)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push)
                    resp_pc <= resp_pc + 32'd4;
            end
            if (redirect_valid) begin
                f2_d_ppreg_is_a_inst <= 1'b0;
            end else if (!stall) begin
                f2_d_ppreg_is_a_inst <= !buf_empty;
                if (!buf_empty) begin
                    f2_d_ppreg_inst <= buf_head.inst;
                    f2_d_ppreg_pc   <= buf_head.pc;
                end
            end
        end
    end

    if_inst_buffer #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (buf_in),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(keep_resp && buf_full && !pop)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic,
// with a scoreboard of the expected in-order instruction stream.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    typedef struct {
        logic [31:0] addr;
        int          acc;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        f2_is;
    logic [31:0] f2_inst;
    logic [31:0] f2_pc;
    logic        fetch_misaligned;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          delivered = 0;
    int          lat = 1;
    bit          jitter = 0;
    logic [31:0] key = 32'h0;

    req_t        pend[$];
    logic [31:0] exp_q[$];

    if_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IBUF_DEPTH (DEPTH)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .imem_req_valid       (imem_req_valid),
        .imem_req_ready       (imem_req_ready),
        .imem_req_addr        (imem_req_addr),
        .imem_resp_valid      (imem_resp_valid),
        .imem_resp_data       (imem_resp_data),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .stall                (stall),
        .f2_d_ppreg_is_a_inst (f2_is),
        .f2_d_ppreg_inst      (f2_inst),
        .f2_d_ppreg_pc        (f2_pc),
        .fetch_misaligned     (fetch_misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic seed(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_inst(input int maxc, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (f2_is) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: no instruction within %0d cycles", nm, maxc);
        end
    endtask

    task automatic do_reset(input bit check_vals);
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        if (check_vals) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_is_a_inst", f2_is, 0);
            chk("rst_inst", f2_inst, 32'h0000_0013);
            chk("rst_pc", f2_pc, RESET_PC);
            chk("rst_misaligned", fetch_misaligned, 0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] t, input bit with_stall);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = t;
        stall          = with_stall;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

    // Instruction memory: in-order, latency >= lat cycles after accept.
    initial begin
        bit          s_hs;
        bit          s_resp;
        logic [31:0] s_addr;
        int          s_cyc;
        req_t        r;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            s_hs   = !rst && imem_req_valid && imem_req_ready;
            s_addr = imem_req_addr;
            s_resp = imem_resp_valid;
            s_cyc  = cyc;
            @(posedge clk);
            if (rst) begin
                pend.delete();
            end else begin
                if (s_resp && pend.size() > 0)
                    void'(pend.pop_front());
                if (s_hs) begin
                    r.addr = s_addr;
                    r.acc  = s_cyc;
                    pend.push_back(r);
                end
            end
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            if (!rst && pend.size() > 0 && (cyc - pend[0].acc) >= lat
                && (!jitter || $urandom_range(3) != 0)) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memf(pend[0].addr);
            end
        end
    end

    // Monitor: each fresh F2->D load must be the next expected instruction.
    initial begin
        bit          p_stall;
        bit          p_redir;
        bit          halted;
        bit          mis_exp;
        logic        p_is;
        logic [31:0] p_pc;
        logic [31:0] p_inst;
        logic [31:0] e;
        p_stall = 0;
        p_redir = 0;
        halted  = 0;
        mis_exp = 0;
        p_is    = 0;
        p_pc    = 0;
        p_inst  = 0;
        seed(RESET_PC);
        forever begin
            @(negedge clk);
            if (rst) begin
                seed(RESET_PC);
                p_stall = 0;
                p_redir = 0;
                halted  = 0;
                mis_exp = 0;
                continue;
            end
            if (p_redir) begin
                chk("redirect_bubble", f2_is, 0);
            end else if (p_stall) begin
                chk("stall_hold_is", f2_is, p_is);
                chk("stall_hold_pc", f2_pc, p_pc);
                chk("stall_hold_inst", f2_inst, p_inst);
            end else if (f2_is) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inst: got pc %h, expected none",
                             f2_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_pc", f2_pc, e);
                    chk("stream_inst", f2_inst, memf(e));
                    delivered++;
                end
            end
            chk("misaligned_flag", fetch_misaligned, mis_exp);
            if (halted)
                chk("halt_no_req", imem_req_valid, 0);
            chk("outstanding_bound", pend.size() <= DEPTH, 1);
            if (redirect_valid) begin
`ifdef IF_MISALIGN_CHECK_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    halted  = 1;
                    mis_exp = 1;
                    exp_q.delete();
                end else
`endif
                seed(redirect_pc & 32'hFFFF_FFFC);
            end
            if (!halted && exp_q.size() < 4)
                exp_q.push_back(exp_q[$] + 32'd4);
            p_stall = stall && !redirect_valid;
            p_redir = redirect_valid;
            p_is    = f2_is;
            p_pc    = f2_pc;
            p_inst  = f2_inst;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_addr;
        logic [31:0] r;
        int          d0;
        bit          ok;

        // Reset values and first request timing.
        do_reset(1);
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("first_cycle_no_req", imem_req_valid, 0);
        @(negedge clk);
        chk("second_cycle_req", imem_req_valid, 1);
        chk("second_cycle_addr", imem_req_addr, RESET_PC);

        // Back-to-back delivery, then a 3-cycle stall holding pc 0x8.
        wait_inst(10, "first_inst");
        chk("tp_pc0", f2_pc, 32'h0);
        chk("tp_inst0", f2_inst, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tp_pc4", f2_pc, 32'h4);
        chk("tp_is4", f2_is, 1);
        @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        chk("tp_pc8", f2_pc, 32'h8);
        chk("tp_inst8", f2_inst, 32'h8);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_pc8_a", f2_pc, 32'h8);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_pc8_b", f2_pc, 32'h8);
        chk("stall_credit_zero", imem_req_valid, 0);
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        chk("release_pc8", f2_pc, 32'h8);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_stall_is", f2_is, 1);
        chk("after_stall_pc", f2_pc, 32'hC);

        // 3-cycle memory, redirect with exactly two requests in flight.
        lat = 3;
        @(posedge clk);
        #1 imem_req_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (pend.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain_outstanding", ok, 1);
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("two_outstanding", pend.size(), 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("in_flush", dut.state, if_fetch_unit_pkg::FLUSH);
        chk("flush_no_req", imem_req_valid, 0);
        wait_inst(30, "after_flush");
        chk("flush_pc", f2_pc, 32'h100);
        chk("flush_inst", f2_inst, 32'h100);

        // Redirect and stall together: stall is ignored.
        lat = 1;
        repeat (8) @(posedge clk);
        redirect_to(32'h200, 1);
        @(negedge clk);
        chk("redir_stall_bubble", f2_is, 0);
        wait_inst(20, "after_redir_stall");
        chk("redir_stall_pc", f2_pc, 32'h200);

        // Memory not ready for 4 cycles: request held, buffer drains.
        repeat (6) @(posedge clk);
        #1 imem_req_ready = 1'b0;
        @(negedge clk);
        hold_addr = f2_pc + 32'd12;
        chk("nready_valid0", imem_req_valid, 1);
        chk("nready_addr0", imem_req_addr, hold_addr);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("nready_valid", imem_req_valid, 1);
            chk("nready_addr", imem_req_addr, hold_addr);
        end
        chk("nready_drained", f2_is, 0);
        @(posedge clk);
        #1 imem_req_ready = 1'b1;

        // Misaligned redirect.
        wait_inst(20, "before_misalign");
        redirect_to(32'h102, 0);
`ifdef IF_MISALIGN_CHECK_EN
        repeat (5) begin
            @(negedge clk);
            chk("mis_flag", fetch_misaligned, 1);
            chk("mis_no_req", imem_req_valid, 0);
            chk("mis_no_inst", f2_is, 0);
        end
`else
        wait_inst(20, "after_misalign");
        chk("mis_resume_pc", f2_pc, 32'h100);
        chk("mis_flag_tied", fetch_misaligned, 0);
`endif

        // Randomized traffic.
        do_reset(0);
        key    = $urandom;
        jitter = 1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            imem_req_ready = ($urandom_range(3) != 0);
            stall          = ($urandom_range(4) == 0);
            if (redirect_valid) begin
                redirect_valid = 1'b0;
            end else if ($urandom_range(19) == 0) begin
                r = $urandom;
                redirect_valid = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
                redirect_pc = {16'h0, r[15:2], 2'b00};
`else
                redirect_pc = {16'h0, r[15:0]};
`endif
                lat = $urandom_range(1, 3);
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        jitter         = 0;
        d0 = delivered;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (delivered >= d0 + 8) begin
                ok = 1;
                break;
            end
        end
        chk("drain_progress", ok, 1);
        chk("random_delivered", delivered > 300, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
